// File: rtl/event_player_pkg.sv
// Shared types and default sizes for the event_player timed stimulus driver.
package event_player_pkg;

    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_DLY_W  = 8;
    localparam int unsigned DEF_TIME_W = 16;
    localparam int unsigned DEF_DEPTH  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [DEF_DLY_W-1:0]  delay;
        logic [DEF_DATA_W-1:0] value;
    } rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock record FIFO; full/empty derived from pointers carrying one extra wrap bit.
module sync_fifo
    import event_player_pkg::*;
#(
    parameter type         T     = rec_t,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic clock,
    input  logic reset_n,
    input  logic wr_en_i,
    input  T     wr_data_i,
    input  logic rd_en_i,
    output T     rd_data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           do_wr;
    logic           do_rd;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/event_player.sv
// Timed stimulus driver: replays buffered {delay, value} records onto a held bus,
// strobing out_changed and stamping out_time only on real value changes.
module event_player
    import event_player_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DLY_W  = DEF_DLY_W,
    parameter int unsigned TIME_W = DEF_TIME_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DLY_W-1:0]  in_delay,
    input  logic [DATA_W-1:0] in_value,
    input  logic              hold,
    output logic [DATA_W-1:0] out_value,
    output logic              out_changed,
    output logic [TIME_W-1:0] out_time,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [DLY_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rec_val_q, rec_val_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic                chg_q, chg_d;
    logic [TIME_W-1:0]   otime_q, otime_d;
    logic [TIME_W-1:0]   time_q;

    logic                fifo_full, fifo_empty;
    logic                push, pop;
    rec_t                wr_rec, head;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;
    assign wr_rec   = '{delay: DEF_DLY_W'(in_delay), value: DEF_DATA_W'(in_value)};

    sync_fifo #(
        .T     (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en_i   (push),
        .wr_data_i (wr_rec),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Next-state: pop/load, countdown, and apply with change detection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rec_val_d = rec_val_q;
        val_d     = val_q;
        chg_d     = 1'b0;
        otime_d   = otime_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !hold) begin
                    pop       = 1'b1;
                    cnt_d     = DLY_W'(head.delay);
                    rec_val_d = DATA_W'(head.value);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (!hold) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DLY_W'(1);
                    end else begin
                        val_d = rec_val_q;
                        if (rec_val_q != val_q) begin
                            chg_d   = 1'b1;
                            otime_d = time_q;
                        end
                        // Chain straight into the next record to keep delay+1 spacing.
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            cnt_d     = DLY_W'(head.delay);
                            rec_val_d = DATA_W'(head.value);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rec_val_q <= '0;
            val_q     <= '0;
            chg_q     <= 1'b0;
            otime_q   <= '0;
            time_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rec_val_q <= rec_val_d;
            val_q     <= val_d;
            chg_q     <= chg_d;
            otime_q   <= otime_d;
            time_q    <= time_q + TIME_W'(1);
        end
    end

    assign out_value   = val_q;
    assign out_changed = chg_q;
    assign out_time    = otime_q;
    assign busy        = (state_q == WAIT) || !fifo_empty;

endmodule

// File: tb/tb_event_player.sv
// Scoreboard bench for event_player: a queue-based reference model predicts each
// value change; a negedge monitor compares every strobe and the handshake status.
module tb_event_player;
    import event_player_pkg::*;

    localparam int unsigned DW = 4;
    localparam int unsigned LW = 8;
    localparam int unsigned TW = 16;
    localparam int unsigned DP = 4;

    logic          clock = 1'b0;
    logic          reset_n, in_valid, in_ready, hold, out_changed, busy;
    logic [LW-1:0] in_delay;
    logic [DW-1:0] in_value, out_value;
    logic [TW-1:0] out_time;

    always #5 clock = ~clock;

    event_player #(.DATA_W(DW), .DLY_W(LW), .TIME_W(TW), .DEPTH(DP)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_delay    (in_delay),
        .in_value    (in_value),
        .hold        (hold),
        .out_value   (out_value),
        .out_changed (out_changed),
        .out_time    (out_time),
        .busy        (busy)
    );

    typedef struct {int delay; int value;} mrec_t;
    typedef struct {int value; int tstamp;} exp_t;

    mrec_t mq[$];
    exp_t  sb[$];
    int    pt[$];
    int    tc = 0;
    bit    m_inflight = 0;
    int    m_need = 0;
    int    m_pend = 0;
    int    m_cur = 0;
    int    len0;
    int    total = 0;
    int    bad = 0;
    int    pulses = 0;
    bit    saw_full = 0;
    bit    mon_en = 0;
    bit    rand_done = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: each popped record needs delay+1 unheld edges before it applies.
    always @(posedge clock) begin
        if (!reset_n) begin
            mq.delete();
            m_inflight = 0;
            m_cur = 0;
            tc = 0;
        end else begin
            len0 = mq.size();
            if (m_inflight && !hold) begin
                m_need--;
                if (m_need == 0) begin
                    if (m_pend != m_cur) sb.push_back('{m_pend, tc});
                    m_cur = m_pend;
                    m_inflight = 0;
                end
            end
            if (!m_inflight && !hold && mq.size() > 0) begin
                m_need = mq[0].delay + 1;
                m_pend = mq[0].value;
                void'(mq.pop_front());
                m_inflight = 1;
            end
            if (in_valid && len0 < DP) mq.push_back('{int'(in_delay), int'(in_value)});
            tc = (tc + 1) % 65536;
        end
    end

    // Monitor: status every cycle, scoreboard pop on every strobe.
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            chk("in_ready", int'(in_ready), int'(mq.size() < DP));
            chk("busy", int'(busy), int'(m_inflight || mq.size() > 0));
            chk("out_value", int'(out_value), m_cur);
            if (!in_ready) saw_full = 1;
            if (out_changed) begin
                pulses++;
                pt.push_back(int'(out_time));
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got value %0d time %0d expected no strobe", out_value, out_time);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_value", int'(out_value), e.value);
                    chk("pulse_time", int'(out_time), e.tstamp);
                end
            end
        end
    end

    task automatic push(input int d, input int v, output int t);
        int  g;
        bit  acc;
        g = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_delay = LW'(d);
        in_value = DW'(v);
        acc = in_ready;
        while (!acc && g < 1000) begin
            @(negedge clock);
            acc = in_ready;
            g++;
        end
        t = tc;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got in_ready 0 expected 1 within 1000 cycles");
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while ((m_inflight || mq.size() != 0) && g < 3000) begin
            @(negedge clock);
            g++;
        end
        if (g >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got busy after 3000 cycles expected idle");
        end
        @(negedge clock);
        #1;
    endtask

    int t0, t1, tp, i0, p0;
    bit acc_in_hold;

    initial begin
        int vals2[7];
        vals2 = '{0, 0, 5, 10, 5, 5, 15};
        reset_n = 1'b0; in_valid = 1'b0; hold = 1'b0; in_delay = '0; in_value = '0;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1 mon_en = 1;
        @(negedge clock);
        reset_n = 1'b1;

        // Idle after reset
        repeat (20) begin
            @(negedge clock);
            #1;
            chk("rst_value", int'(out_value), 0);
            chk("rst_changed", int'(out_changed), 0);
            chk("rst_time", int'(out_time), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_ready", int'(in_ready), 1);
        end

        // Same-value filtering at delay 9
        i0 = pt.size();
        p0 = pulses;
        foreach (vals2[k]) push(9, vals2[k], tp);
        wait_done();
        chk("seq_pulses", pulses - p0, 4);
        if (pt.size() >= i0 + 4) begin
            chk("seq_gap1", pt[i0+1] - pt[i0], 10);
            chk("seq_gap2", pt[i0+2] - pt[i0+1], 10);
            chk("seq_gap3", pt[i0+3] - pt[i0+2], 20);
        end

        // Zero delay and maximum delay
        push(0, 3, t0);
        wait_done();
        chk("d0_value", int'(out_value), 3);
        chk("d0_time", int'(out_time), t0 + 2);
        push(255, 7, t1);
        wait_done();
        chk("dmax_value", int'(out_value), 7);
        chk("dmax_time", int'(out_time), t1 + 2 + 255);

        // Fill the FIFO past depth
        saw_full = 0;
        p0 = pulses;
        push(20, 1, tp); push(20, 2, tp); push(20, 3, tp); push(20, 4, tp); push(20, 6, tp);
        wait_done();
        chk("full_seen", int'(saw_full), 1);
        chk("full_pulses", pulses - p0, 5);

        // Hold for 7 cycles while countdown sits at 3
        i0 = pt.size();
        push(5, 9, t0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        hold = 1'b1;
        fork
            begin
                push(0, 12, tp);
                acc_in_hold = hold;
            end
            begin
                repeat (7) @(negedge clock);
                hold = 1'b0;
            end
        join
        wait_done();
        chk("hold_accept", int'(acc_in_hold), 1);
        if (pt.size() >= i0 + 1) chk("hold_time", pt[i0], t0 + 2 + 5 + 7);
        chk("hold_last", int'(out_value), 12);

        // Randomised records with random hold
        fork
            begin
                for (int k = 0; k < 40; k++) push(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)), tp);
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clock);
                    hold = (($urandom % 6) == 0);
                end
                hold = 1'b0;
            end
        join
        wait_done();

        // Reset mid-WAIT with three queued
        push(20, 1, tp); push(20, 2, tp); push(20, 3, tp); push(20, 4, tp);
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("mid_rst_value", int'(out_value), 0);
        chk("mid_rst_changed", int'(out_changed), 0);
        chk("mid_rst_time", int'(out_time), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        p0 = pulses;
        repeat (60) @(negedge clock);
        #1;
        chk("post_rst_pulses", pulses - p0, 0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
